// File: rtl/m_wbuart.sv
// Wishbone slave UART, 8N1 LSB first, fixed baud of CLKDIV clocks per bit.
// Latency: zero-wait-state bus (ACK_O = STB_I); TX line falls one edge after an accepted DATA write.
// Backpressure: single TX holding path; a DATA write while txbusy is dropped, RX overrun flagged.
// Ports: CLK_I/RST_I clock and async active-high reset; STB_I/WE_I/ADR_I/DAT_I/DAT_O/ACK_O
//        Wishbone slave (ADR_I 0 = DATA, 1 = STATUS); usartRX async serial in; usartTX registered out.
module m_wbuart #(
  parameter int CLKDIV = 104
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        ADR_I,
  input  logic [7:0]  DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        usartRX,
  output logic        usartTX
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV / 2 - 1);

  typedef enum logic [1:0] {TIDLE, TSTART, TDATA, TSTOP} tx_state_t;
  typedef enum logic [1:0] {RIDLE, RSTART, RDATA, RSTOP} rx_state_t;

  // Bus decode
  logic data_wr, data_rd, stat_wr;
  assign data_wr = STB_I & WE_I & ~ADR_I;
  assign data_rd = STB_I & ~WE_I & ~ADR_I;
  assign stat_wr = STB_I & WE_I & ADR_I;

  // ---------------- Transmitter ----------------
  tx_state_t     tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]    tx_bit, tx_bit_nx;
  logic [7:0]    tx_sh, tx_sh_nx;
  logic          tx_line_nx;
  logic          txbusy;

  assign txbusy = (tx_state != TIDLE);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tx_state <= TIDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      usartTX  <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_sh    <= tx_sh_nx;
      usartTX  <= tx_line_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_sh_nx    = tx_sh;
    tx_line_nx  = usartTX;
    case (tx_state)
      TIDLE: begin
        if (data_wr) begin
          tx_state_nx = TSTART;
          tx_cnt_nx   = BIT_LAST;
          tx_bit_nx   = '0;
          tx_sh_nx    = DAT_I;
          tx_line_nx  = 1'b0;
        end
      end
      TSTART: begin
        if (tx_cnt == '0) begin
          tx_state_nx = TDATA;
          tx_cnt_nx   = BIT_LAST;
          tx_bit_nx   = '0;
          tx_line_nx  = tx_sh[0];
          tx_sh_nx    = tx_sh >> 1;
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      TDATA: begin
        // tx_bit counts data bits already placed on the line.
        if (tx_cnt == '0) begin
          tx_cnt_nx = BIT_LAST;
          if (tx_bit == 3'd7) begin
            tx_state_nx = TSTOP;
            tx_line_nx  = 1'b1;
          end else begin
            tx_bit_nx  = tx_bit + 3'd1;
            tx_line_nx = tx_sh[0];
            tx_sh_nx   = tx_sh >> 1;
          end
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      TSTOP: begin
        if (tx_cnt == '0) begin
          tx_state_nx = TIDLE;
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      default: tx_state_nx = TIDLE;
    endcase
  end

  // ---------------- Receiver ----------------
  logic          rx_meta, rxs;
  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]    rx_bit, rx_bit_nx;
  logic [7:0]    rx_sh, rx_sh_nx;
  logic [7:0]    rxdata, rxdata_nx;
  logic          rxvalid, rxvalid_nx;
  logic          overrun, overrun_nx;
  logic          ferr, ferr_nx;
  logic          stop_good, stop_bad;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rx_state <= RIDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rxdata   <= '0;
      rxvalid  <= 1'b0;
      overrun  <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_meta  <= usartRX;
      rxs      <= rx_meta;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_sh    <= rx_sh_nx;
      rxdata   <= rxdata_nx;
      rxvalid  <= rxvalid_nx;
      overrun  <= overrun_nx;
      ferr     <= ferr_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_sh_nx    = rx_sh;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;
    case (rx_state)
      RIDLE: begin
        if (!rxs) begin
          rx_state_nx = RSTART;
          rx_cnt_nx   = HALF_LAST;
        end
      end
      RSTART: begin
        // Mid-start-bit check: a line back high means a glitch, not a frame.
        if (rx_cnt == '0) begin
          if (rxs) begin
            rx_state_nx = RIDLE;
          end else begin
            rx_state_nx = RDATA;
            rx_cnt_nx   = BIT_LAST;
            rx_bit_nx   = '0;
          end
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      RDATA: begin
        if (rx_cnt == '0) begin
          rx_sh_nx  = {rxs, rx_sh[7:1]};
          rx_cnt_nx = BIT_LAST;
          if (rx_bit == 3'd7) begin
            rx_state_nx = RSTOP;
          end else begin
            rx_bit_nx = rx_bit + 3'd1;
          end
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      RSTOP: begin
        // Leave at mid-stop-bit so the next start edge is never missed.
        if (rx_cnt == '0) begin
          rx_state_nx = RIDLE;
          stop_good   = rxs;
          stop_bad    = ~rxs;
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      default: rx_state_nx = RIDLE;
    endcase
  end

  // Flag update: a DATA read in the same cycle frees the buffer for the new byte,
  // and new error events take priority over W1C clears.
  always_comb begin
    rxdata_nx  = rxdata;
    rxvalid_nx = rxvalid;
    if (data_rd) begin
      rxvalid_nx = 1'b0;
    end
    if (stop_good && (!rxvalid || data_rd)) begin
      rxdata_nx  = rx_sh;
      rxvalid_nx = 1'b1;
    end
    overrun_nx = (stop_good & rxvalid & ~data_rd) | (overrun & ~(stat_wr & DAT_I[2]));
    ferr_nx    = stop_bad | (ferr & ~(stat_wr & DAT_I[3]));
  end

  // ---------------- Bus read path ----------------
  assign ACK_O = STB_I;

  always_comb begin
    DAT_O = '0;
    if (STB_I) begin
      if (ADR_I) begin
        DAT_O = {28'h0, ferr, overrun, txbusy, rxvalid};
      end else begin
        DAT_O = {24'h0, rxdata};
      end
    end
  end

endmodule

// File: tb/tb_m_wbuart.sv
module tb_m_wbuart;

  localparam int CLKDIV = 8;
  localparam int FRAME  = 10 * CLKDIV;
  localparam int RX_LAT = 2 + CLKDIV / 2 + 9 * CLKDIV;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        STB_I;
  logic        WE_I;
  logic        ADR_I;
  logic [7:0]  DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        usartRX;
  logic        usartTX;

  int tests_run = 0;
  int fails     = 0;

  logic [7:0] rx_q[$];
  logic       tx_q[$];

  m_wbuart #(.CLKDIV(CLKDIV)) dut (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .STB_I  (STB_I),
    .WE_I   (WE_I),
    .ADR_I  (ADR_I),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .ACK_O  (ACK_O),
    .usartRX(usartRX),
    .usartTX(usartTX)
  );

  always #5 CLK_I = ~CLK_I;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_read(input logic adr, output logic [31:0] d);
    STB_I = 1'b1;
    WE_I  = 1'b0;
    ADR_I = adr;
    #2;
    d = DAT_O;
    check("ack", {31'h0, ACK_O}, 32'h1);
    tick();
    STB_I = 1'b0;
  endtask

  task automatic bus_write(input logic adr, input logic [7:0] data);
    STB_I = 1'b1;
    WE_I  = 1'b1;
    ADR_I = adr;
    DAT_I = data;
    tick();
    STB_I = 1'b0;
    WE_I  = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic adr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(adr, d);
    check(tag, d, exp);
  endtask

  // mode 0: plain frame; mode 1: caller holds a STATUS read, record edge of rxvalid rise;
  // mode 2: issue a DATA read whose acked cycle ends on the stop-sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input int mode,
                            output int first_vld);
    logic [9:0] fr;
    logic [7:0] exp;
    fr = {stopb, d, 1'b0};
    first_vld = -1;
    usartRX = fr[0];
    for (int i = 0; i < FRAME; i++) begin
      @(posedge CLK_I);
      #1;
      usartRX = (i + 1 < FRAME) ? fr[(i + 1) / CLKDIV] : 1'b1;
      if (mode == 1 && first_vld < 0 && DAT_O[0]) first_vld = i;
      if (mode == 2 && i == RX_LAT - 1) begin
        STB_I = 1'b1;
        WE_I  = 1'b0;
        ADR_I = 1'b0;
        #1;
        exp = rx_q.pop_front();
        check("race_rd", DAT_O, {24'h0, exp});
      end
      if (mode == 2 && i == RX_LAT) STB_I = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  tfr;
    logic        eb;
    logic [7:0]  eby;
    int          fv;
    int          lows;

    RST_I   = 1'b1;
    STB_I   = 1'b0;
    WE_I    = 1'b0;
    ADR_I   = 1'b0;
    DAT_I   = 8'h00;
    usartRX = 1'b1;
    repeat (3) @(posedge CLK_I);
    #1;
    check("rst_tx", {31'h0, usartTX}, 32'h1);
    check("idle_bus_zero", DAT_O, 32'h0);
    RST_I = 1'b0;
    tick();
    expect_reg("rst_status", 1'b1, 32'h0);

    // ---- TX frame 0xA5, ignored second write at +5 ----
    tfr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < FRAME; i++) tx_q.push_back(tfr[i / CLKDIV]);
    bus_write(1'b0, 8'hA5);
    STB_I = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 5) begin
        ADR_I = 1'b0;
        WE_I  = 1'b1;
        DAT_I = 8'h00;
      end else begin
        ADR_I = 1'b1;
        WE_I  = 1'b0;
      end
      #1;
      eb = tx_q.pop_front();
      check("tx_line", {31'h0, usartTX}, {31'h0, eb});
      if (i != 5) check("tx_busy", {31'h0, DAT_O[1]}, 32'h1);
      tick();
    end
    ADR_I = 1'b1;
    WE_I  = 1'b0;
    #1;
    check("tx_busy_clear", {31'h0, DAT_O[1]}, 32'h0);
    check("tx_idle_line", {31'h0, usartTX}, 32'h1);
    STB_I = 1'b0;
    lows = 0;
    for (int i = 0; i < 3 * CLKDIV; i++) begin
      tick();
      if (!usartTX) lows++;
    end
    check("tx_no_second_frame", lows, 32'h0);

    // ---- RX loopback 0x3C with latency check ----
    rx_q.push_back(8'h3C);
    STB_I = 1'b1;
    WE_I  = 1'b0;
    ADR_I = 1'b1;
    send_frame(8'h3C, 1'b1, 1, fv);
    STB_I = 1'b0;
    check("rx_latency", fv, RX_LAT);
    idle(2 * CLKDIV);
    eby = rx_q.pop_front();
    expect_reg("rx_data", 1'b0, {24'h0, eby});
    expect_reg("rx_status_after_rd", 1'b1, 32'h0);

    // ---- Overrun ----
    rx_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 0, fv);
    idle(2 * CLKDIV);
    send_frame(8'h22, 1'b1, 0, fv);
    idle(2 * CLKDIV);
    expect_reg("ovr_status", 1'b1, 32'h5);
    bus_write(1'b1, 8'h04);
    expect_reg("ovr_cleared", 1'b1, 32'h1);
    eby = rx_q.pop_front();
    expect_reg("ovr_data", 1'b0, {24'h0, eby});
    expect_reg("ovr_status_end", 1'b1, 32'h0);

    // ---- Race: DATA read on the stop-sample edge of 0x77 ----
    rx_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 0, fv);
    idle(2 * CLKDIV);
    rx_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 2, fv);
    idle(2 * CLKDIV);
    expect_reg("race_status", 1'b1, 32'h1);
    eby = rx_q.pop_front();
    expect_reg("race_data", 1'b0, {24'h0, eby});
    expect_reg("race_status_end", 1'b1, 32'h0);

    // ---- Glitch rejection then valid frame ----
    usartRX = 1'b0;
    idle(2);
    usartRX = 1'b1;
    idle(3 * CLKDIV);
    expect_reg("glitch_status", 1'b1, 32'h0);
    rx_q.push_back(8'h9A);
    send_frame(8'h9A, 1'b1, 0, fv);
    idle(2 * CLKDIV);
    expect_reg("post_glitch_status", 1'b1, 32'h1);
    eby = rx_q.pop_front();
    expect_reg("post_glitch_data", 1'b0, {24'h0, eby});

    // ---- Framing error ----
    send_frame(8'h55, 1'b0, 0, fv);
    idle(2 * CLKDIV);
    expect_reg("ferr_status", 1'b1, 32'h8);
    bus_write(1'b1, 8'h08);
    expect_reg("ferr_cleared", 1'b1, 32'h0);
    send_frame(8'h0F, 1'b0, 0, fv);
    idle(2 * CLKDIV);
    expect_reg("ferr_again", 1'b1, 32'h8);
    expect_reg("ferr_data_kept", 1'b0, 32'h9A);

    // ---- Reset mid-transmission ----
    bus_write(1'b0, 8'hC3);
    tick();
    check("rst_pre_tx_low", {31'h0, usartTX}, 32'h0);
    #3;
    RST_I = 1'b1;
    #1;
    check("rst_tx_immediate", {31'h0, usartTX}, 32'h1);
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    tick();
    expect_reg("rst_mid_status", 1'b1, 32'h0);
    expect_reg("rst_rxdata", 1'b0, 32'h0);
    lows = 0;
    for (int i = 0; i < 12 * CLKDIV; i++) begin
      tick();
      if (!usartTX) lows++;
    end
    check("rst_tx_quiet", lows, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/m_wbuart.md
# m_wbuart

Wishbone slave UART for the midgetv icebreaker top. It replaces the bit-bang UART, where software toggles the TX pin and polls the RX pin, with hardware serialisation at a fixed baud rate. It sits directly downstream of the core's Wishbone master. It is selected by the same address-decoded strobe and drives the TX/RX pins. It offers a one-byte transmit holding path and a one-byte receive buffer with status flags. Frame format is 8N1, LSB first.

## Interface
Parameters:
- CLKDIV, 104: clock cycles per bit (12 MHz / 115200). Legal range is 4..65535. The bit counter width is $clog2(CLKDIV).

Ports:
- CLK_I, input, 1: system clock.
- RST_I, input, 1: reset. Asynchronous and active-high.
- STB_I, input, 1: address-decoded Wishbone strobe.
- WE_I, input, 1: write enable.
- ADR_I, input, 1: register select. 0 = DATA, 1 = STATUS.
- DAT_I, input, 8: write data.
- DAT_O, output, 32: read data. It is zero whenever STB_I = 0, so it can be OR-ed on the shared bus.
- ACK_O, output, 1: equals STB_I combinationally, giving a single-cycle ack with no wait states.
- usartRX, input, 1: serial input, asynchronous to CLK_I.
- usartTX, output, 1: serial output, registered.

## Operation
Register map:
- DATA write: starts a transmission if txbusy = 0. If txbusy = 1 the write is silently ignored.
- DATA read: DAT_O[7:0] = rxdata and DAT_O[31:8] = 0. The read clears rxvalid on the acked cycle.
- STATUS read: DAT_O[0] = rxvalid, [1] = txbusy, [2] = overrun, [3] = ferr. All other bits are 0.
- STATUS write: write-1-to-clear. DAT_I[2] = 1 clears overrun and DAT_I[3] = 1 clears ferr. Other bits are ignored.

TX state machine (TIDLE → TSTART → TDATA → TSTOP → TIDLE):
- Accepted write: latch DAT_I into the shift register, set txbusy, enter TSTART, and drive usartTX = 0.
- Each state lasts exactly CLKDIV cycles.
- TDATA shifts out 8 bits, LSB first.
- TSTOP drives 1.
- At the end of TSTOP, clear txbusy and return to TIDLE.

RX input conditioning:
- usartRX passes through a 2-flop synchroniser.
- The receiver uses only the synchronised value, rxs.

RX state machine (RIDLE → RSTART → RDATA → RSTOP → RIDLE):
- RIDLE: rxs = 0 enters RSTART and loads the counter for CLKDIV/2 (integer division).
- RSTART, at the half-bit sample: if rxs = 1, treat it as a glitch and return to RIDLE with no flag change. Otherwise go to RDATA.
- RDATA: sample every CLKDIV cycles, 8 samples, LSB first.
- RSTOP, after CLKDIV more cycles, sample rxs:
  - rxs = 1 and rxvalid = 0: rxdata ← byte, rxvalid ← 1.
  - rxs = 1 and rxvalid = 1: set overrun. The new byte is discarded and the old rxdata is kept.
  - rxs = 0: set ferr and discard the byte. rxvalid and rxdata are unchanged.
- In every case RSTOP returns to RIDLE on the same edge. This gives mid-stop-bit resynchronisation, so back-to-back frames are received.

Simultaneous events:
- DATA read in the same cycle as a good stop sample: the new byte is stored, rxvalid stays 1, and no overrun is flagged.
- Good stop sample while rxvalid = 1 and overrun is being W1C-cleared in the same cycle: overrun ends set (set wins).
- DATA write on the same edge that txbusy clears: ignored, because txbusy is sampled before the edge.

Reset (asynchronous, takes effect immediately, including mid-frame):
- usartTX = 1, txbusy = 0, rxvalid = 0, overrun = 0, ferr = 0, rxdata = 0.
- Both state machines go to idle and all counters are cleared.
- Synchroniser flops reset to 1.

## Timing
- ACK_O and DAT_O are combinational from STB_I, ADR_I and registers. State updates occur on the edge that ends the acked cycle.
- TX: for a DATA write acked in cycle n, usartTX falls at edge n+1.
  - txbusy is 1 from edge n+1 through edge n+1+10·CLKDIV, where it returns to 0.
  - The stop bit is high for CLKDIV cycles before txbusy clears.
- RX: let edge 0 be the first edge that samples usartRX low.
  - The start is detected at edge 2 (synchroniser delay).
  - rxvalid, overrun or ferr updates at edge 2 + CLKDIV/2 + 9·CLKDIV.
- The minimum accepted start pulse is about CLKDIV/2 cycles. Shorter pulses are rejected as glitches.

## Test plan
Use CLKDIV = 8 unless stated otherwise.
- Reset: assert RST_I mid-transmission → usartTX = 1 immediately. STATUS read returns 0x0. No further edges on usartTX.
- TX frame: write DATA = 0xA5 → usartTX shows start(0), then 1,0,1,0,0,1,0,1, then 1, each 8 cycles wide. txbusy = 1 for exactly 80 cycles. A second write at cycle +5 is ignored and the line shows no second frame.
- RX loopback: drive an 8N1 frame of 0x3C → rxvalid = 1 at cycle 2 + 4 + 72 after the start edge. DATA read returns 0x0000003C. The next STATUS read returns 0x0.
- Overrun: send 0x11 then 0x22 without reading → STATUS = 0x5. DATA = 0x11. STATUS write 0x4 → STATUS = 0x1 until DATA is read.
- Framing and glitch:
  - Frame 0x55 with stop = 0 → STATUS = 0x8 and rxvalid stays 0.
  - A 2-cycle low pulse → no state change, and a following valid frame is received correctly.
- Race: a DATA read coinciding with the stop sample of the next byte 0x77 → STATUS = 0x1 with no overrun. A subsequent DATA read returns 0x77.
